dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- MEM-stage data-memory bridge between the pipelined datapath and a single-port, variable-latency data bus (request/grant plus response-valid protocol).
- Takes the MEM-stage access (ALUResultM, WriteDataM, byteEnable, MemWriteM), runs one bus transaction, and returns the load word on RD_data.
- Holds the pipeline with mem_stall until the transaction completes.
- One transaction in flight at a time.

Parameters:
- AW, 32, bus address width; the upper 30 bits of ALUResultM are used, zero-extended or truncated to AW.
- TIMEOUT, 255, cycles to wait for bus_gnt or bus_rvalid before the access is declared faulted. Range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_valid_m  in  1  a load or store occupies MEM this cycle.
- MemWriteM  in  1  1 = store, 0 = load.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, already lane-aligned.
- byteEnable  in  4  store lane enables.
- pipe_adv  in  1  the pipeline advances at the end of this cycle (the downstream ~stalled).
- RD_data  out  32  load word to load-extend logic.
- mem_stall  out  1  hold the pipeline.
- fault  out  1  the completed access saw a bus error or timeout.
- bus_req  out  1  request.
- bus_we  out  1  write.
- bus_addr  out  AW  word-aligned address, {addr[AW-1:2], 2'b00}.
- bus_wdata  out  32  write data.
- bus_be  out  4  byte enables.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  response valid (returned for reads and writes).
- bus_rdata  in  32  read data.
- bus_err  in  1  error, qualified by bus_rvalid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; RD_data=0, fault=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0; timeout counter=0.
  - Reset mid-transaction abandons it immediately: bus_req drops asynchronously. Any late gnt/rvalid is ignored because the FSM is in IDLE.
- mem_stall is combinational = (state==IDLE & mem_valid_m & ~skip) | state==REQ | state==WAIT | (state==DONE & 0). It is low in IDLE without a request and always low in DONE.
- IDLE:
  - If mem_valid_m: latch address, data, enables and direction into the bus_* registers, then go to REQ.
  - Loads drive bus_be=4'b1111 regardless of byteEnable. Stores drive bus_be=byteEnable.
  - skip = MemWriteM & (byteEnable==0). A skipped store makes no bus access, asserts no stall, and stays in IDLE.
- REQ:
  - bus_req=1; address, data and enables are held stable until grant.
  - On bus_gnt: bus_req=0 next cycle, counter cleared, go to WAIT.
- WAIT:
  - On bus_rvalid: if a load, capture bus_rdata into RD_data; fault_next=bus_err; go to DONE.
  - A store's bus_rvalid leaves RD_data unchanged.
  - bus_rvalid is only sampled in WAIT; rvalid in the grant cycle is not legal and is ignored.
- Timeout:
  - In REQ or WAIT the counter increments every cycle.
  - When counter==TIMEOUT: drop bus_req, set fault_next=1, RD_data unchanged, go to DONE.
- DONE:
  - mem_stall=0; RD_data and fault are valid and stable.
  - Stays in DONE while pipe_adv=0. This covers the multiplier/divider freezing EX/MEM, and prevents re-issuing the same access.
  - On pipe_adv=1: go to IDLE; fault clears on that transition.
- Back-to-back accesses: the next MEM-stage access is seen in IDLE one cycle after DONE.
  - Minimum load latency: IDLE → REQ (gnt) → WAIT (rvalid) → DONE gives 3 stall cycles.
- RD_data holds its last captured value outside DONE.
- fault is high only in DONE.

Test Plan:
- Load, zero wait:
  - Stimulus: mem_valid_m=1, MemWriteM=0, ALUResultM=0x0000_1006; gnt on the first REQ cycle; rvalid one cycle later with rdata=0xDEAD_BEEF.
  - Required: bus_addr=0x1004, bus_be=1111, bus_we=0; mem_stall high exactly 3 cycles; RD_data=0xDEAD_BEEF in DONE; fault=0.
- Byte store with delayed grant:
  - Stimulus: ALUResultM=0x2003, byteEnable=1000, WriteDataM=0xAB00_0000; gnt after 4 cycles.
  - Required: bus_req held 4 cycles with stable bus_addr=0x2000, bus_be=1000, bus_wdata=0xAB00_0000; RD_data unchanged.
- Downstream freeze:
  - Stimulus: load completes while pipe_adv=0 for 5 cycles.
  - Required: FSM stays in DONE; exactly one bus_req pulse total; RD_data stable throughout.
- Zero-enable store:
  - Stimulus: MemWriteM=1, byteEnable=0000.
  - Required: bus_req never asserts; mem_stall stays 0.
- Error and timeout:
  - Stimulus (a): rvalid with bus_err=1. Required: fault=1 in DONE only.
  - Stimulus (b): TIMEOUT=8, gnt never arrives. Required: bus_req drops after 8 cycles, fault=1, mem_stall released.
- Async reset in WAIT:
  - Stimulus: reset=0 asserted mid-cycle while in WAIT, then a late rvalid.
  - Required: bus_req=0 and RD_data=0 immediately; FSM in IDLE; the late rvalid does not change RD_data.

Source files
------------

// File: rtl/dmem_bridge_if.sv
// Single-port data bus between the MEM-stage bridge (master) and the memory system (slave).
// Request/grant for the address phase; response-valid for the data and error phase.
interface dmem_bridge_if #(
  parameter int AW = 32
) ();
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_be;
  logic          bus_gnt;
  logic          bus_rvalid;
  logic [31:0]   bus_rdata;
  logic          bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/dmem_bridge.sv
// MEM-stage data-memory bridge: turns one pipeline load/store into one bus transaction,
// holds the pipeline until it completes, and presents the load word and fault status.
module dmem_bridge #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_m,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  input  logic        pipe_adv,
  output logic [31:0] RD_data,
  output logic        mem_stall,
  output logic        fault,
  dmem_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t        r_state;
  logic [15:0]   r_cnt;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [AW-1:0] r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic [3:0]    r_bus_be;
  logic [31:0]   r_rd_data;
  logic          r_fault;

  logic          w_skip;
  logic [15:0]   w_cnt_inc;
  logic          w_tmo;
  logic [AW-1:0] w_addr;

  assign w_skip    = MemWriteM & (byteEnable == 4'b0000);
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_tmo     = (w_cnt_inc == TMO);
  // Word-align first, then the size cast zero-extends or truncates to the bus width.
  assign w_addr    = AW'(ALUResultM & 32'hFFFF_FFFC);

  assign mem_stall = ((r_state == IDLE) & mem_valid_m & ~w_skip) |
                     (r_state == REQ) | (r_state == WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_rd_data   <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_valid_m && !w_skip) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= MemWriteM;
            r_bus_addr  <= w_addr;
            r_bus_wdata <= WriteDataM;
            r_bus_be    <= MemWriteM ? byteEnable : 4'b1111;
            r_cnt       <= '0;
            r_state     <= REQ;
          end
        end
        REQ: begin
          // A grant arriving on the last allowed cycle still wins over the timeout.
          if (bus.bus_gnt) begin
            r_bus_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= WAIT;
          end else if (w_tmo) begin
            r_bus_req <= 1'b0;
            r_fault   <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        WAIT: begin
          if (bus.bus_rvalid) begin
            if (!r_bus_we) r_rd_data <= bus.bus_rdata;
            r_fault <= bus.bus_err;
            r_state <= DONE;
          end else if (w_tmo) begin
            r_fault <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DONE: begin
          // Waiting here while the pipeline is frozen keeps the access from re-issuing.
          if (pipe_adv) begin
            r_fault <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_be    = r_bus_be;
  assign RD_data       = r_rd_data;
  assign fault         = r_fault;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: the driver queues expected bus requests and completions,
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid_m;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [3:0]  byteEnable;
  logic        pipe_adv;
  logic [31:0] RD_data;
  logic        mem_stall;
  logic        fault;

  dmem_bridge_if #(.AW(32)) bus_if ();

  dmem_bridge #(.AW(32), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_valid_m (mem_valid_m),
    .MemWriteM   (MemWriteM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .byteEnable  (byteEnable),
    .pipe_adv    (pipe_adv),
    .RD_data     (RD_data),
    .mem_stall   (mem_stall),
    .fault       (fault),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        f;
    int          stall;
  } cmp_t;

  req_t rq[$];
  cmp_t cq[$];

  int          checks = 0;
  int          errors = 0;
  int          req_pulses = 0;
  logic [31:0] sb_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor state
  req_t        cur_rq;
  cmp_t        cur_c;
  logic        prev_req = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_adv = 1'b0;
  logic        in_done = 1'b0;
  logic        done_now;
  logic [31:0] model_rd = 32'h0;
  logic        model_f = 1'b0;
  int          req_run = 0;
  int          stall_run = 0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_rd_data", RD_data, 32'h0);
      chk("rst_fault", {31'b0, fault}, 32'h0);
      chk("rst_bus_req", {31'b0, bus_if.bus_req}, 32'h0);
      chk("rst_bus_we", {31'b0, bus_if.bus_we}, 32'h0);
      chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
      chk("rst_bus_be", {28'b0, bus_if.bus_be}, 32'h0);
      chk("rst_stall", {31'b0, mem_stall}, 32'h0);
      cq.delete();
      model_rd   = 32'h0;
      model_f    = 1'b0;
      in_done    = 1'b0;
      prev_req   = 1'b0;
      prev_stall = 1'b0;
      prev_adv   = pipe_adv;
    end else begin
      if (bus_if.bus_req && !prev_req) begin
        if (rq.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_req: got bus_req=1, expected 0 at %0t", $time);
          cur_rq = '{we: bus_if.bus_we, addr: bus_if.bus_addr, wdata: bus_if.bus_wdata,
                     be: bus_if.bus_be, len: 0};
        end else begin
          cur_rq = rq.pop_front();
        end
        req_pulses++;
        req_run = 0;
      end
      if (bus_if.bus_req) begin
        req_run++;
        chk("req_we", {31'b0, bus_if.bus_we}, {31'b0, cur_rq.we});
        chk("req_addr", bus_if.bus_addr, cur_rq.addr);
        chk("req_wdata", bus_if.bus_wdata, cur_rq.wdata);
        chk("req_be", {28'b0, bus_if.bus_be}, {28'b0, cur_rq.be});
      end
      if (!bus_if.bus_req && prev_req) chk("req_len", req_run, cur_rq.len);

      if (mem_stall) begin
        if (!prev_stall) begin
          stall_run = 0;
          if (cq.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_stall: got mem_stall=1, expected 0 at %0t", $time);
          end
        end
        stall_run++;
      end

      done_now = in_done && !prev_adv;
      if (prev_stall && !mem_stall && cq.size() != 0) begin
        cur_c = cq.pop_front();
        chk("stall_cycles", stall_run, cur_c.stall);
        model_rd = cur_c.rd;
        model_f  = cur_c.f;
        done_now = 1'b1;
      end
      chk("rd_data", RD_data, model_rd);
      chk("fault", {31'b0, fault}, {31'b0, done_now ? model_f : 1'b0});

      in_done    = done_now;
      prev_adv   = pipe_adv;
      prev_stall = mem_stall;
      prev_req   = bus_if.bus_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gnt_dly < 0 means the grant never comes and the access must time out.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input logic err, input int hold);
    int req_len;
    int stall_len;
    req_len   = (gnt_dly < 0) ? TMO : gnt_dly + 1;
    stall_len = 1 + req_len + ((gnt_dly < 0) ? 0 : rv_dly + 1);
    if (gnt_dly >= 0 && !we) sb_rd = rdata;
    rq.push_back('{we: we, addr: addr & 32'hFFFF_FFFC, wdata: wdata,
                   be: we ? be : 4'b1111, len: req_len});
    cq.push_back('{rd: sb_rd, f: (gnt_dly < 0) ? 1'b1 : err, stall: stall_len});
    mem_valid_m = 1'b1;
    MemWriteM   = we;
    ALUResultM  = addr;
    WriteDataM  = wdata;
    byteEnable  = be;
    pipe_adv    = 1'b0;
    step();
    if (gnt_dly < 0) begin
      repeat (TMO) step();
    end else begin
      repeat (gnt_dly) step();
      bus_if.bus_gnt = 1'b1;
      step();
      bus_if.bus_gnt = 1'b0;
      repeat (rv_dly) step();
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = rdata;
      bus_if.bus_err    = err;
      step();
      bus_if.bus_rvalid = 1'b0;
      bus_if.bus_err    = 1'b0;
      bus_if.bus_rdata  = 32'h0;
    end
    repeat (hold) step();
    pipe_adv = 1'b1;
    step();
    pipe_adv    = 1'b0;
    mem_valid_m = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b0;
    mem_valid_m       = 1'b0;
    MemWriteM         = 1'b0;
    ALUResultM        = 32'h0;
    WriteDataM        = 32'h0;
    byteEnable        = 4'h0;
    pipe_adv          = 1'b0;
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'h0;
    bus_if.bus_err    = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    // Zero-wait load, unaligned address
    access(1'b0, 32'h0000_1006, 32'h1234_5678, 4'b0000, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    // Byte store, grant in the fourth request cycle
    access(1'b1, 32'h0000_2003, 32'hAB00_0000, 4'b1000, 3, 0, 32'h0, 1'b0, 0);
    // Load completing into a frozen pipeline
    access(1'b0, 32'h0000_3000, 32'h0, 4'b1111, 1, 2, 32'h0BAD_F00D, 1'b0, 5);

    // Zero-enable store makes no bus access
    mem_valid_m = 1'b1;
    MemWriteM   = 1'b1;
    ALUResultM  = 32'h0000_3100;
    WriteDataM  = 32'hFFFF_FFFF;
    byteEnable  = 4'b0000;
    pipe_adv    = 1'b1;
    #1;
    chk("skip_stall", {31'b0, mem_stall}, 32'h0);
    repeat (3) step();
    mem_valid_m = 1'b0;
    pipe_adv    = 1'b0;
    step();

    // Load with bus error, then a word store, then a grant that never arrives
    access(1'b0, 32'h0000_4008, 32'h0, 4'b0000, 0, 1, 32'h5555_AAAA, 1'b1, 2);
    access(1'b1, 32'h0000_5000, 32'h0102_0304, 4'b1111, 2, 0, 32'h0, 1'b0, 0);
    access(1'b0, 32'h0000_6000, 32'h0, 4'b0000, -1, 0, 32'h0, 1'b0, 1);

    // Asynchronous reset while waiting for the response
    rq.push_back('{we: 1'b0, addr: 32'h0000_7000, wdata: 32'h0, be: 4'b1111, len: 1});
    cq.push_back('{rd: 32'h0, f: 1'b0, stall: 3});
    mem_valid_m = 1'b1;
    MemWriteM   = 1'b0;
    ALUResultM  = 32'h0000_7000;
    WriteDataM  = 32'h0;
    step();
    bus_if.bus_gnt = 1'b1;
    step();
    bus_if.bus_gnt = 1'b0;
    #1;
    reset       = 1'b0;
    mem_valid_m = 1'b0;
    sb_rd       = 32'h0;
    #1;
    chk("async_req", {31'b0, bus_if.bus_req}, 32'h0);
    chk("async_rd_data", RD_data, 32'h0);
    chk("async_stall", {31'b0, mem_stall}, 32'h0);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hFFFF_FFFF;
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'h0;
    step();

    // Recovery load after reset
    access(1'b0, 32'h0000_8004, 32'h0, 4'b0000, 0, 0, 32'h1357_9BDF, 1'b0, 0);
    repeat (3) step();
    chk("req_pulses", req_pulses, 8);
    chk("queues_drained", rq.size() + cq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
